// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM encoding,
// reader grant ids and AXI-lite style response codes.
package mem_arbiter_pkg;

    // FSM state encoding
    localparam logic [2:0] STATE_IDLE   = 3'd0;
    localparam logic [2:0] STATE_IFU_RD = 3'd1;
    localparam logic [2:0] STATE_LSU_RD = 3'd2;
    localparam logic [2:0] STATE_LSU_WR = 3'd3;
    localparam logic [2:0] STATE_LSU_B  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = STATE_IDLE,
        ST_IFU_RD = STATE_IFU_RD,
        ST_LSU_RD = STATE_LSU_RD,
        ST_LSU_WR = STATE_LSU_WR,
        ST_LSU_B  = STATE_LSU_B
    } arb_state_t;

    // Reader ids, used for the round-robin last_rd flag
    localparam logic GRANT_IFU = 1'b0;
    localparam logic GRANT_LSU = 1'b1;

    // Response codes carried on rresp/bresp
    localparam logic [2:0] RESP_OKAY   = 3'b000;
    localparam logic [2:0] RESP_SLVERR = 3'b010;

endpackage

// File: rtl/mem_arbiter.sv
// Arbiter sharing one AXI-lite style sram slave between the IFU (read only)
// and the LSU (read/write). One whole transaction at a time, never
// interleaved; a write request always wins in IDLE, reads alternate when
// both are pending.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_LEN     = 32,
    parameter int DATA_BIT_NUM = DATA_LEN / 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // IFU read master
    input  logic                    ifu_arvalid,
    output logic                    ifu_arready,
    input  logic [DATA_LEN-1:0]     ifu_raddr,
    output logic                    ifu_rvalid,
    input  logic                    ifu_rready,
    output logic [DATA_LEN-1:0]     ifu_rdata,
    output logic [2:0]              ifu_rresp,
    // LSU read channels
    input  logic                    lsu_arvalid,
    output logic                    lsu_arready,
    input  logic [DATA_LEN-1:0]     lsu_raddr,
    output logic                    lsu_rvalid,
    input  logic                    lsu_rready,
    output logic [DATA_LEN-1:0]     lsu_rdata,
    output logic [2:0]              lsu_rresp,
    // LSU write channels
    input  logic                    lsu_awvalid,
    output logic                    lsu_awready,
    input  logic [DATA_LEN-1:0]     lsu_waddr,
    input  logic                    lsu_wvalid,
    output logic                    lsu_wready,
    input  logic [DATA_LEN-1:0]     lsu_wdata,
    input  logic [DATA_BIT_NUM-1:0] lsu_wstrob,
    output logic                    lsu_bvalid,
    input  logic                    lsu_bready,
    output logic [2:0]              lsu_bresp,
    // sram slave side
    output logic                    s_arvalid,
    input  logic                    s_arready,
    output logic [DATA_LEN-1:0]     s_raddr,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    input  logic [DATA_LEN-1:0]     s_rdata,
    input  logic [2:0]              s_rresp,
    output logic                    s_awvalid,
    input  logic                    s_awready,
    output logic [DATA_LEN-1:0]     s_waddr,
    output logic                    s_wvalid,
    input  logic                    s_wready,
    output logic [DATA_LEN-1:0]     s_wdata,
    output logic [DATA_BIT_NUM-1:0] s_wstrob,
    input  logic                    s_bvalid,
    output logic                    s_bready,
    input  logic [2:0]              s_bresp
);

    arb_state_t state, state_nxt;
    logic       last_rd, last_rd_nxt;
    logic       aw_done, aw_done_nxt;
    logic       w_done, w_done_nxt;

    // Channel handshakes as seen in LSU_WR, with completed channels masked
    logic aw_fire, w_fire;
    assign aw_fire = lsu_awvalid & ~aw_done & s_awready;
    assign w_fire  = lsu_wvalid  & ~w_done  & s_wready;

    // State, round-robin history and write-channel flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            last_rd <= GRANT_IFU;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            last_rd <= last_rd_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
        end
    end

    // Next-state decision and the per-state channel mux
    always_comb begin
        state_nxt   = state;
        last_rd_nxt = last_rd;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;

        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = RESP_OKAY;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = RESP_OKAY;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        lsu_bresp   = RESP_OKAY;

        s_arvalid   = 1'b0;
        s_raddr     = '0;
        s_rready    = 1'b0;
        s_awvalid   = 1'b0;
        s_waddr     = '0;
        s_wvalid    = 1'b0;
        s_wdata     = '0;
        s_wstrob    = '0;
        s_bready    = 1'b0;

        case (state)
            ST_IDLE: begin
                // Either write channel showing up claims the slave first;
                // the other write channel is allowed to follow later.
                if (lsu_awvalid || lsu_wvalid) begin
                    state_nxt = ST_LSU_WR;
                end else if (ifu_arvalid && lsu_arvalid) begin
                    state_nxt = (last_rd == GRANT_IFU) ? ST_LSU_RD : ST_IFU_RD;
                end else if (ifu_arvalid) begin
                    state_nxt = ST_IFU_RD;
                end else if (lsu_arvalid) begin
                    state_nxt = ST_LSU_RD;
                end
            end

            ST_IFU_RD: begin
                s_arvalid   = ifu_arvalid;
                s_raddr     = ifu_raddr;
                ifu_arready = s_arready;
                ifu_rvalid  = s_rvalid;
                ifu_rdata   = s_rdata;
                ifu_rresp   = s_rresp;
                s_rready    = ifu_rready;
                if (s_rvalid && ifu_rready) begin
                    state_nxt   = ST_IDLE;
                    last_rd_nxt = GRANT_IFU;
                end
            end

            ST_LSU_RD: begin
                s_arvalid   = lsu_arvalid;
                s_raddr     = lsu_raddr;
                lsu_arready = s_arready;
                lsu_rvalid  = s_rvalid;
                lsu_rdata   = s_rdata;
                lsu_rresp   = s_rresp;
                s_rready    = lsu_rready;
                if (s_rvalid && lsu_rready) begin
                    state_nxt   = ST_IDLE;
                    last_rd_nxt = GRANT_LSU;
                end
            end

            ST_LSU_WR: begin
                // AW and W run independently; once a channel has
                // handshaken its valid is hidden from the slave.
                s_awvalid   = lsu_awvalid & ~aw_done;
                s_waddr     = lsu_waddr;
                lsu_awready = s_awready & ~aw_done;
                s_wvalid    = lsu_wvalid & ~w_done;
                s_wdata     = lsu_wdata;
                s_wstrob    = lsu_wstrob;
                lsu_wready  = s_wready & ~w_done;
                if (aw_fire) aw_done_nxt = 1'b1;
                if (w_fire)  w_done_nxt  = 1'b1;
                if ((aw_done || aw_fire) && (w_done || w_fire)) begin
                    state_nxt = ST_LSU_B;
                end
            end

            ST_LSU_B: begin
                lsu_bvalid = s_bvalid;
                lsu_bresp  = s_bresp;
                s_bready   = lsu_bready;
                if (s_bvalid && lsu_bready) begin
                    state_nxt   = ST_IDLE;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end
            end

            default: begin
                state_nxt   = ST_IDLE;
                aw_done_nxt = 1'b0;
                w_done_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small behavioural sram slave.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [31:0] ifu_raddr, ifu_rdata;
    logic [2:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_raddr, lsu_rdata;
    logic [2:0]  lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready, lsu_bvalid, lsu_bready;
    logic [31:0] lsu_waddr, lsu_wdata;
    logic [3:0]  lsu_wstrob;
    logic [2:0]  lsu_bresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_raddr, s_rdata;
    logic [2:0]  s_rresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_waddr, s_wdata;
    logic [3:0]  s_wstrob;
    logic [2:0]  s_bresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.DATA_LEN(32), .DATA_BIT_NUM(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_raddr(ifu_raddr),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_raddr(lsu_raddr),
        .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready), .lsu_waddr(lsu_waddr),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata), .lsu_wstrob(lsu_wstrob),
        .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_raddr(s_raddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_waddr(s_waddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrob(s_wstrob),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
    );

    // OR of every DUT output, for "everything is quiet" checks
    logic any_out;
    assign any_out = |{ifu_arready, ifu_rvalid, ifu_rdata, ifu_rresp,
                       lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp,
                       lsu_awready, lsu_wready, lsu_bvalid, lsu_bresp,
                       s_arvalid, s_raddr, s_rready, s_awvalid, s_waddr,
                       s_wvalid, s_wdata, s_wstrob, s_bready};

    // ---------------- sram slave model ----------------
    // word i initially holds 0xA000_0000+i, except word 0 (0x413) and word 0x40
    logic [31:0] mem [0:255];
    logic        mem_loaded = 1'b0;
    logic        have_aw, have_w;
    logic [31:0] aw_addr_l, w_data_l;
    logic [3:0]  w_strb_l;
    logic [2:0]  rresp_cfg = RESP_OKAY;

    assign s_arready = !s_rvalid;
    assign s_awready = !have_aw && !s_bvalid;
    assign s_wready  = !have_w && !s_bvalid;

    // slave: one-cycle read latency, write commits once AW and W both arrived
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_rvalid <= 1'b0; s_rdata <= '0; s_rresp <= '0;
            s_bvalid <= 1'b0; s_bresp <= '0;
            have_aw <= 1'b0; have_w <= 1'b0;
            aw_addr_l <= '0; w_data_l <= '0; w_strb_l <= '0;
            if (!mem_loaded) begin
                for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 + i;
                mem[0]     <= 32'h0000_0413;
                mem[8'h40] <= 32'h1234_5678;
                mem_loaded <= 1'b1;
            end
        end else begin
            if (s_arvalid && s_arready) begin
                s_rvalid <= 1'b1; s_rdata <= mem[s_raddr[9:2]]; s_rresp <= rresp_cfg;
            end else if (s_rvalid && s_rready) begin
                s_rvalid <= 1'b0; s_rdata <= '0;
            end
            if (s_awvalid && s_awready) begin have_aw <= 1'b1; aw_addr_l <= s_waddr; end
            if (s_wvalid && s_wready) begin have_w <= 1'b1; w_data_l <= s_wdata; w_strb_l <= s_wstrob; end
            if (have_aw && have_w) begin
                for (int b = 0; b < 4; b++)
                    if (w_strb_l[b]) mem[aw_addr_l[9:2]][b*8 +: 8] <= w_data_l[b*8 +: 8];
                s_bvalid <= 1'b1; s_bresp <= RESP_OKAY;
                have_aw <= 1'b0; have_w <= 1'b0;
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end
        end
    end

    // ---------------- monitors ----------------
    int arv_cycles = 0, arv_at_b = 0, aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0;
    int ifu_rv_cycles = 0, lsu_busy = 0;
    bit grant_log[$];

    // slave-side handshake counters and master AR grant order
    always @(posedge clk) begin
        if (s_arvalid) arv_cycles <= arv_cycles + 1;
        if (s_awvalid && s_awready) aw_hs_cnt <= aw_hs_cnt + 1;
        if (s_wvalid && s_wready) w_hs_cnt <= w_hs_cnt + 1;
        if (s_bvalid && s_bready) begin
            b_hs_cnt <= b_hs_cnt + 1;
            arv_at_b <= arv_cycles;
        end
        if (ifu_arvalid && ifu_arready) grant_log.push_back(1'b0);
        if (lsu_arvalid && lsu_arready) grant_log.push_back(1'b1);
    end

    // master-side activity counters sampled mid-cycle
    always @(negedge clk) begin
        if (ifu_rvalid) ifu_rv_cycles <= ifu_rv_cycles + 1;
        if (|{lsu_arready, lsu_rvalid, lsu_rdata, lsu_rresp, lsu_awready,
              lsu_wready, lsu_bvalid, lsu_bresp}) lsu_busy <= lsu_busy + 1;
    end

    // ---------------- drivers (no checking) ----------------
    // Full read on one master; caller is positioned just after a posedge.
    task automatic do_read(input bit sel, input logic [31:0] addr,
                           output logic [31:0] data, output logic [2:0] resp, output bit to);
        bit got;
        to = 1'b0; got = 1'b0; data = '0; resp = '0;
        if (sel) begin lsu_arvalid = 1'b1; lsu_raddr = addr; end
        else     begin ifu_arvalid = 1'b1; ifu_raddr = addr; end
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = sel ? lsu_arready : ifu_arready;
        end
        if (!got) to = 1'b1;
        @(posedge clk); #1;
        if (sel) begin lsu_arvalid = 1'b0; lsu_rready = 1'b1; end
        else     begin ifu_arvalid = 1'b0; ifu_rready = 1'b1; end
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = sel ? lsu_rvalid : ifu_rvalid;
        end
        if (!got) to = 1'b1;
        data = sel ? lsu_rdata : ifu_rdata;
        resp = sel ? lsu_rresp : ifu_rresp;
        @(posedge clk); #1;
        if (sel) lsu_rready = 1'b0; else ifu_rready = 1'b0;
    endtask

    // LSU store; W is raised first, AW follows after 'lead' cycles.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead,
                            output logic [2:0] bresp, output bit to);
        bit a_d, w_d, a_hs, w_hs, got;
        int cyc;
        a_d = 0; w_d = 0; cyc = 0; to = 0; got = 0; bresp = '0;
        lsu_waddr = addr; lsu_wdata = data; lsu_wstrob = strb;
        lsu_wvalid = 1'b1; lsu_awvalid = (lead == 0);
        for (int i = 0; i < 100 && !(a_d && w_d); i++) begin
            @(negedge clk);
            a_hs = lsu_awvalid && lsu_awready;
            w_hs = lsu_wvalid && lsu_wready;
            @(posedge clk); #1;
            if (a_hs) begin a_d = 1; lsu_awvalid = 1'b0; end
            if (w_hs) begin w_d = 1; lsu_wvalid = 1'b0; end
            cyc++;
            if (!a_d && cyc >= lead) lsu_awvalid = 1'b1;
        end
        if (!(a_d && w_d)) to = 1'b1;
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        lsu_bready = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = lsu_bvalid;
        end
        if (!got) to = 1'b1;
        bresp = lsu_bresp;
        @(posedge clk); #1;
        lsu_bready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (any_out !== 1'b0) begin errors++; $display("FAIL reset_outputs: got %b want 0", any_out); end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (any_out !== 1'b0) begin errors++; $display("FAIL idle_outputs: got %b want 0", any_out); end
        @(posedge clk); #1;
    endtask

    task automatic test_ifu_read();
        logic [31:0] d; logic [2:0] r; bit to;
        int rv0, lb0;
        rv0 = ifu_rv_cycles; lb0 = lsu_busy;
        do_read(1'b0, 32'h8000_0000, d, r, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL ifu_read_timeout: got %0d want 0", to); end
        checks++; if (d !== 32'h0000_0413) begin errors++; $display("FAIL ifu_rdata: got %h want 00000413", d); end
        checks++; if (r !== RESP_OKAY) begin errors++; $display("FAIL ifu_rresp: got %h want 0", r); end
        checks++; if (ifu_rv_cycles - rv0 !== 1) begin errors++; $display("FAIL ifu_rvalid_cycles: got %0d want 1", ifu_rv_cycles - rv0); end
        checks++; if (lsu_busy - lb0 !== 0) begin errors++; $display("FAIL lsu_quiet: got %0d want 0", lsu_busy - lb0); end
    endtask

    task automatic test_round_robin();
        logic [31:0] la, lb, ia, ib; logic [2:0] r0, r1, r2, r3; bit t0, t1, t2, t3;
        bit exp_g [4];
        int n0;
        exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        n0 = grant_log.size();
        fork
            begin do_read(1'b1, 32'h8000_0010, la, r0, t0); do_read(1'b1, 32'h8000_0014, lb, r1, t1); end
            begin do_read(1'b0, 32'h8000_0020, ia, r2, t2); do_read(1'b0, 32'h8000_0024, ib, r3, t3); end
        join
        checks++; if ({t0, t1, t2, t3} !== 4'b0) begin errors++; $display("FAIL rr_timeout: got %b want 0000", {t0, t1, t2, t3}); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (grant_log.size() <= n0 + k || grant_log[n0 + k] !== exp_g[k]) begin
                errors++;
                $display("FAIL rr_grant%0d: got %0d want %0d (1=LSU)", k,
                         (grant_log.size() > n0 + k) ? int'(grant_log[n0 + k]) : -1, exp_g[k]);
            end
        end
        checks++;
        if ({la, lb, ia, ib} !== {32'hA000_0004, 32'hA000_0005, 32'hA000_0008, 32'hA000_0009}) begin
            errors++; $display("FAIL rr_data: got %h %h %h %h want a0000004 a0000005 a0000008 a0000009", la, lb, ia, ib);
        end
    endtask

    task automatic test_store();
        logic [31:0] d; logic [2:0] r, br; bit to, tr;
        int aw0, w0, b0;
        aw0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
        do_write(32'h8000_0100, 32'hDEAD_BEEF, 4'b0011, 2, br, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL store_timeout: got %0d want 0", to); end
        checks++;
        if ({aw_hs_cnt - aw0, w_hs_cnt - w0, b_hs_cnt - b0} !== {32'd1, 32'd1, 32'd1}) begin
            errors++; $display("FAIL store_handshakes: aw=%0d w=%0d b=%0d want 1 1 1", aw_hs_cnt - aw0, w_hs_cnt - w0, b_hs_cnt - b0);
        end
        checks++; if (br !== RESP_OKAY) begin errors++; $display("FAIL store_bresp: got %h want 0", br); end
        do_read(1'b1, 32'h8000_0100, d, r, tr);
        checks++; if (tr !== 1'b0 || d !== 32'h1234_BEEF) begin errors++; $display("FAIL store_readback: got %h want 1234beef", d); end
    endtask

    task automatic test_write_priority();
        logic [31:0] d, d2; logic [2:0] r, br; bit tw, tr, t2;
        int arv0;
        arv0 = arv_cycles;
        fork
            do_write(32'h8000_0200, 32'hCAFE_F00D, 4'b1111, 0, br, tw);
            do_read(1'b0, 32'h8000_0030, d, r, tr);
        join
        checks++; if ({tw, tr} !== 2'b00) begin errors++; $display("FAIL prio_timeout: got %b want 00", {tw, tr}); end
        checks++; if (arv_at_b !== arv0) begin errors++; $display("FAIL prio_ar_before_b: got %0d ar cycles want 0", arv_at_b - arv0); end
        checks++; if (d !== 32'hA000_000C) begin errors++; $display("FAIL prio_ifu_data: got %h want a000000c", d); end
        do_read(1'b1, 32'h8000_0200, d2, r, t2);
        checks++; if (t2 !== 1'b0 || d2 !== 32'hCAFE_F00D) begin errors++; $display("FAIL prio_readback: got %h want cafef00d", d2); end
    endtask

    task automatic test_rready_stall();
        bit got;
        got = 1'b0;
        ifu_arvalid = 1'b1; ifu_raddr = 32'h8000_0040; ifu_rready = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); got = ifu_arready; end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL stall_ar_timeout: got %0d want 1", got); end
        @(posedge clk); #1;
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b1; lsu_raddr = 32'h8000_0044;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({ifu_rvalid, lsu_arready, s_arvalid, ifu_rdata} !== {3'b100, 32'hA000_0010}) begin
                errors++;
                $display("FAIL stall_hold%0d: rvalid=%b lsu_arready=%b s_arvalid=%b rdata=%h want 1 0 0 a0000010",
                         k, ifu_rvalid, lsu_arready, s_arvalid, ifu_rdata);
            end
            @(posedge clk); #1;
        end
        ifu_rready = 1'b1;
        @(posedge clk); #1 ifu_rready = 1'b0;
        @(negedge clk);
        checks++;
        if ({ifu_rvalid, lsu_arready} !== 2'b00) begin
            errors++; $display("FAIL stall_idle_gap: rvalid=%b lsu_arready=%b want 0 0", ifu_rvalid, lsu_arready);
        end
        @(negedge clk);
        checks++; if (lsu_arready !== 1'b1) begin errors++; $display("FAIL stall_lsu_grant: got %b want 1", lsu_arready); end
        @(posedge clk); #1;
        lsu_arvalid = 1'b0; lsu_rready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); got = lsu_rvalid; end
        checks++; if (!got || lsu_rdata !== 32'hA000_0011) begin errors++; $display("FAIL stall_lsu_data: got %h want a0000011", lsu_rdata); end
        @(posedge clk); #1 lsu_rready = 1'b0;
    endtask

    task automatic test_error_resp();
        logic [31:0] d; logic [2:0] r; bit to;
        rresp_cfg = RESP_SLVERR;
        do_read(1'b1, 32'h8000_0048, d, r, to);
        rresp_cfg = RESP_OKAY;
        checks++; if (to !== 1'b0 || r !== RESP_SLVERR) begin errors++; $display("FAIL err_rresp: got %h want 2", r); end
        checks++; if (d !== 32'hA000_0012) begin errors++; $display("FAIL err_rdata: got %h want a0000012", d); end
        do_read(1'b0, 32'h8000_0000, d, r, to);
        checks++; if (to !== 1'b0 || d !== 32'h0000_0413) begin errors++; $display("FAIL err_next_read: got %h want 00000413", d); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d; logic [2:0] r, br; bit to, tr, got;
        int aw0;
        got = 1'b0;
        lsu_awvalid = 1'b1; lsu_waddr = 32'h8000_0300;
        for (int i = 0; i < 50 && !got; i++) begin @(negedge clk); got = lsu_awready; end
        @(posedge clk); #1 lsu_awvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({got, lsu_wready, lsu_awready} !== 3'b110) begin
            errors++; $display("FAIL rst_pre_state: aw_seen=%b wready=%b awready=%b want 1 1 0", got, lsu_wready, lsu_awready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (any_out !== 1'b0) begin errors++; $display("FAIL rst_async_outputs: got %b want 0", any_out); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        aw0 = aw_hs_cnt;
        do_write(32'h8000_0300, 32'h0BAD_CAFE, 4'b1111, 0, br, to);
        checks++;
        if (to !== 1'b0 || aw_hs_cnt - aw0 !== 1) begin
            errors++; $display("FAIL rst_flags_cleared: timeout=%0d aw_hs=%0d want 0 1", to, aw_hs_cnt - aw0);
        end
        do_read(1'b0, 32'h8000_0300, d, r, tr);
        checks++; if (tr !== 1'b0 || d !== 32'h0BAD_CAFE) begin errors++; $display("FAIL rst_readback: got %h want 0badcafe", d); end
    endtask

    initial begin
        ifu_arvalid = 0; ifu_raddr = '0; ifu_rready = 0;
        lsu_arvalid = 0; lsu_raddr = '0; lsu_rready = 0;
        lsu_awvalid = 0; lsu_waddr = '0; lsu_wvalid = 0; lsu_wdata = '0; lsu_wstrob = '0; lsu_bready = 0;
        test_reset();
        test_ifu_read();
        test_round_robin();
        test_store();
        test_write_priority();
        test_rready_stall();
        test_error_resp();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
